c1541_sd_arbiter: RTL

//  Shares one HPS SD sector interface (lba/rd/wr/ack plus 512-byte buffer port) between NDRV
//  c1541_sd drive instances on clk_sys. Round-robin grant, one sector transfer at a time.

---
 rtl/c1541_sd_arbiter_pkg.sv | 13 +
 rtl/c1541_sd_arbiter_rr_pick.sv | 28 ++
 rtl/c1541_sd_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/c1541_sd_arbiter_pkg.sv
// Shared types for the c1541 SD sector-interface arbiter.
package c1541_sd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_NDRV = 4;

endpackage

// File: rtl/c1541_sd_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index after 'last', wrapping mod NDRV.
module c1541_sd_arbiter_rr_pick #(
  parameter int NDRV = 4,
  parameter int IW   = $clog2(NDRV)
) (
  input  logic [NDRV-1:0] pend,
  input  logic [IW-1:0]   last,
  output logic            any,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest pending one wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NDRV; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NDRV);
      if (pend[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/c1541_sd_arbiter.sv
// Round-robin sharing of one host SD sector lane between NDRV c1541 drive instances.
module c1541_sd_arbiter
  import c1541_sd_arbiter_pkg::*;
#(
  parameter int NDRV  = DEFAULT_NDRV,
  parameter int LBA_W = 32
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [NDRV*LBA_W-1:0]     req_lba,
  input  logic [NDRV-1:0]           req_rd,
  input  logic [NDRV-1:0]           req_wr,
  output logic [NDRV-1:0]           req_ack,
  input  logic [NDRV*8-1:0]         req_buff_din,
  output logic [NDRV-1:0]           req_buff_wr,
  output logic [LBA_W-1:0]          sd_lba,
  output logic                      sd_rd,
  output logic                      sd_wr,
  input  logic                      sd_ack,
  input  logic                      sd_buff_wr,
  output logic [7:0]                sd_buff_din,
  output logic [$clog2(NDRV)-1:0]   sd_img,
  output logic                      busy
);

  localparam int IW = $clog2(NDRV);

  state_t           state_reg, state_next;
  logic [IW-1:0]    last_reg, last_next;
  logic [IW-1:0]    img_reg, img_next;
  logic [LBA_W-1:0] lba_reg, lba_next;
  logic             rd_reg, rd_next;
  logic             wr_reg, wr_next;

  logic [LBA_W-1:0] lba_arr [NDRV];
  logic [7:0]       din_arr [NDRV];
  logic [NDRV-1:0]  pend;
  logic             pick_any;
  logic [IW-1:0]    pick_idx;

  assign pend = req_rd | req_wr;
  assign busy = (state_reg != ST_IDLE);

  generate
    for (genvar gi = 0; gi < NDRV; gi++) begin : g_drv
      assign lba_arr[gi]     = req_lba[gi*LBA_W +: LBA_W];
      assign din_arr[gi]     = req_buff_din[gi*8 +: 8];
      assign req_ack[gi]     = sd_ack & busy & (img_reg == IW'(gi));
      assign req_buff_wr[gi] = sd_buff_wr & busy & (img_reg == IW'(gi));
    end
  endgenerate

  c1541_sd_arbiter_rr_pick #(.NDRV(NDRV), .IW(IW)) u_pick (
    .pend (pend),
    .last (last_reg),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      last_reg  <= IW'(NDRV - 1);
      img_reg   <= '0;
      lba_reg   <= '0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      img_reg   <= img_next;
      lba_reg   <= lba_next;
      rd_reg    <= rd_next;
      wr_reg    <= wr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    img_next   = img_reg;
    lba_next   = lba_reg;
    rd_next    = rd_reg;
    wr_next    = wr_reg;
    case (state_reg)
      ST_IDLE: begin
        // A host ack still high here is left over from a reset mid-transfer; let it drain.
        if (!sd_ack && pick_any) begin
          img_next   = pick_idx;
          lba_next   = lba_arr[pick_idx];
          rd_next    = req_rd[pick_idx];
          wr_next    = ~req_rd[pick_idx];
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sd_ack) begin
          rd_next    = 1'b0;
          wr_next    = 1'b0;
          state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!sd_ack) state_next = ST_DONE;
      end
      ST_DONE: begin
        last_next  = img_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign sd_lba      = lba_reg;
  assign sd_rd       = rd_reg;
  assign sd_wr       = wr_reg;
  assign sd_img      = img_reg;
  assign sd_buff_din = din_arr[img_reg];

endmodule
